if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 41 ++++
 rtl/if_stage_pc_reg.sv | 38 +++
 rtl/if_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared cpu definitions for the fetch stage
// Purpose: opcode constants, register codes, width defaults and the fetch
// state encoding shared by if_stage and its sub-module.
package if_stage_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int OPCODE_W   = 5;

  // 5-bit opcodes held in instruction bits [15:11]
  localparam logic [OPCODE_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_STORE = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_JUMP  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_BZ    = 5'b01001;

  // General register codes
  localparam logic [2:0] GR0 = 3'd0;
  localparam logic [2:0] GR1 = 3'd1;
  localparam logic [2:0] GR2 = 3'd2;
  localparam logic [2:0] GR3 = 3'd3;
  localparam logic [2:0] GR4 = 3'd4;
  localparam logic [2:0] GR5 = 3'd5;
  localparam logic [2:0] GR6 = 3'd6;
  localparam logic [2:0] GR7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// rtl/if_stage_pc_reg.sv - program counter with load/increment/hold
// Purpose: holds the fetch PC; load has priority over increment, otherwise hold.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (PC -> 0)
//   i_load           load i_load_addr into PC
//   i_load_addr      redirect target
//   i_inc            increment PC modulo 2^ADDR_W
//   o_pc             current PC
module pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus1;

  // Natural wrap at 2^ADDR_W
  assign w_pc_plus1 = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= w_pc_plus1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register and fetch FSM
// Purpose: fetches one instruction per cycle from external memory, handles
// stall, branch redirect/flush and HALT detection.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   enable           start fetching (sampled in IDLE only)
//   stall            freeze PC and IF/ID
//   branch_flag      redirect PC to branch_addr and flush IF/ID
//   branch_addr      redirect target
//   i_addr           instruction memory address (= PC)
//   i_data           instruction word read combinationally at i_addr
//   id_ir, id_pc     IF/ID instruction and its PC+1
//   id_valid         IF/ID holds a real instruction
//   halted           fetch stopped on HALT
module if_stage
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] id_ir,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              halted
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [DATA_W-1:0]   r_id_ir;
  logic [ADDR_W-1:0]   r_id_pc;
  logic                r_id_valid;

  logic [ADDR_W-1:0]   w_pc;
  logic [ADDR_W-1:0]   w_pc_plus1;
  logic [OPCODE_W-1:0] w_opcode;
  logic                w_pc_load;
  logic                w_pc_inc;
  logic                w_ifid_we;
  logic [DATA_W-1:0]   w_nxt_ir;
  logic [ADDR_W-1:0]   w_nxt_pc;
  logic                w_nxt_valid;

  pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load      (w_pc_load),
    .i_load_addr (branch_addr),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc)
  );

  assign w_pc_plus1 = w_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_opcode   = i_data[DATA_W-1 -: OPCODE_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // IF/ID write data defaults to a NOP bubble; only an unstalled RUN fetch
  // without a redirect loads a real instruction.
  always_comb begin
    w_next_state = r_state;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_ifid_we    = 1'b0;
    w_nxt_ir     = '0;
    w_nxt_pc     = '0;
    w_nxt_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ifid_we = 1'b1;
        if (enable) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (branch_flag) begin
          // Redirect wins over both stall and a HALT on the wrong path
          w_pc_load = 1'b1;
          w_ifid_we = 1'b1;
        end else if (!stall) begin
          w_ifid_we   = 1'b1;
          w_nxt_ir    = i_data;
          w_nxt_pc    = w_pc_plus1;
          w_nxt_valid = 1'b1;
          if (is_halt(w_opcode)) begin
            w_next_state = ST_HALT;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        w_ifid_we = 1'b1;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_ifid_we    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_ir    <= '0;
      r_id_pc    <= '0;
      r_id_valid <= 1'b0;
    end else if (w_ifid_we) begin
      r_id_ir    <= w_nxt_ir;
      r_id_pc    <= w_nxt_pc;
      r_id_valid <= w_nxt_valid;
    end
  end

  assign i_addr   = w_pc;
  assign id_ir    = r_id_ir;
  assign id_pc    = r_id_pc;
  assign id_valid = r_id_valid;
  assign halted   = (r_state == ST_HALT);

endmodule
